// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Takes one PC at a time from the PC register and issues one read to
// instruction memory, with at most one read outstanding. It then hands the
// {pc, inst} pair to decode over a valid/ready handshake. ifu_flush kills
// whatever fetch is in flight.
// Optional feature: define IFU_MISALIGN_TRAP_EN to trap PCs with pc[1:0] != 0.
// A trapped PC skips the memory access and presents RESET_INST with
// ifu_tx_misalign set.
module ifu_fetch #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ifu_rx_valid,
  output logic        ifu_rx_ready,
  input  logic [31:0] ifu_rx_pc,
  input  logic        ifu_flush,
  output logic        ifu_mem_req_valid,
  input  logic        ifu_mem_req_ready,
  output logic [31:0] ifu_mem_req_addr,
  input  logic        ifu_mem_rsp_valid,
  input  logic [31:0] ifu_mem_rsp_data,
  output logic        ifu_tx_valid,
  input  logic        ifu_tx_ready,
  output logic [31:0] ifu_tx_pc,
  output logic [31:0] ifu_tx_inst,
  output logic        ifu_tx_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a PC
    S_REQ,    // presenting the read request
    S_RSP,    // request accepted, waiting for data
    S_DRAIN,  // flushed while waiting: swallow the orphan response
    S_TX      // presenting {pc, inst} to decode
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        mis_q, mis_d;

  logic rx_fire;
  logic req_fire;
  logic tx_fire;

  assign rx_fire  = ifu_rx_valid && ifu_rx_ready;
  assign req_fire = ifu_mem_req_valid && ifu_mem_req_ready;
  assign tx_fire  = ifu_tx_valid && ifu_tx_ready;

  // State and datapath registers
  // NOTE: non-blocking assignments in clocked blocks, so every flop samples
  // the pre-edge value of every other flop, whatever order the lines are in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
      inst_q  <= RESET_INST;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic and register updates
  // NOTE: every target gets a default first. A path that leaves a
  // combinational target unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          pc_d    = ifu_rx_pc;
          state_d = S_REQ;
`ifdef IFU_MISALIGN_TRAP_EN
          mis_d = |ifu_rx_pc[1:0];
          if (|ifu_rx_pc[1:0]) begin
            inst_d  = RESET_INST;
            state_d = S_TX;
          end
`endif
        end
      end
      S_REQ: begin
        if (ifu_flush)     state_d = S_IDLE;
        else if (req_fire) state_d = S_RSP;
      end
      S_RSP: begin
        // Flush wins over data arriving in the same cycle. Because the
        // response has now arrived, there is nothing left to drain.
        if (ifu_mem_rsp_valid && ifu_flush) begin
          state_d = S_IDLE;
        end else if (ifu_mem_rsp_valid) begin
          inst_d  = ifu_mem_rsp_data;
          state_d = S_TX;
        end else if (ifu_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ifu_mem_rsp_valid) state_d = S_IDLE;
      end
      S_TX: begin
        // ifu_tx_valid is gated by flush, so a flush cycle can never
        // also be a handshake.
        if (ifu_flush || tx_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs. Each one is gated combinationally by flush.
  always_comb begin
    ifu_rx_ready      = (state_q == S_IDLE) && !ifu_flush;
    ifu_mem_req_valid = (state_q == S_REQ)  && !ifu_flush;
    ifu_tx_valid      = (state_q == S_TX)   && !ifu_flush;
  end

  // Data outputs come straight from registers, so no ifu_rx_* input reaches
  // them combinationally. They also stay stable under backpressure.
  assign ifu_mem_req_addr = pc_q;
  assign ifu_tx_pc        = pc_q;
  assign ifu_tx_inst      = inst_q;
  // mis_q is only ever written in the trap build. In the default build it
  // holds its reset value of 0, so this output is tied low.
  assign ifu_tx_misalign  = mis_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed, table-driven bench for ifu_fetch.
// Each table row is one clock cycle. The row's inputs are applied and the
// DUT outputs are compared in that same cycle, then the clock advances.
// Hand-written sequences cover reset, fetch latency, misalignment and a
// reset in the middle of a fetch.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifu_rx_valid;
  logic        ifu_rx_ready;
  logic [31:0] ifu_rx_pc;
  logic        ifu_flush;
  logic        ifu_mem_req_valid;
  logic        ifu_mem_req_ready;
  logic [31:0] ifu_mem_req_addr;
  logic        ifu_mem_rsp_valid;
  logic [31:0] ifu_mem_rsp_data;
  logic        ifu_tx_valid;
  logic        ifu_tx_ready;
  logic [31:0] ifu_tx_pc;
  logic [31:0] ifu_tx_inst;
  logic        ifu_tx_misalign;

  ifu_fetch dut (
    .clk               (clk),
    .rstn              (rstn),
    .ifu_rx_valid      (ifu_rx_valid),
    .ifu_rx_ready      (ifu_rx_ready),
    .ifu_rx_pc         (ifu_rx_pc),
    .ifu_flush         (ifu_flush),
    .ifu_mem_req_valid (ifu_mem_req_valid),
    .ifu_mem_req_ready (ifu_mem_req_ready),
    .ifu_mem_req_addr  (ifu_mem_req_addr),
    .ifu_mem_rsp_valid (ifu_mem_rsp_valid),
    .ifu_mem_rsp_data  (ifu_mem_rsp_data),
    .ifu_tx_valid      (ifu_tx_valid),
    .ifu_tx_ready      (ifu_tx_ready),
    .ifu_tx_pc         (ifu_tx_pc),
    .ifu_tx_inst       (ifu_tx_inst),
    .ifu_tx_misalign   (ifu_tx_misalign)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rxv;
    logic [31:0] pc;
    logic        fl;
    logic        rqr;
    logic        rsv;
    logic [31:0] rsd;
    logic        txr;
    logic        e_rxr;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_txv;
    logic [31:0] e_txpc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rxv, input logic [31:0] pc, input logic fl, input logic rqr,
                     input logic rsv, input logic [31:0] rsd, input logic txr,
                     input logic e_rxr, input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_txv, input logic [31:0] e_txpc, input logic [31:0] e_inst);
    vec_t v;
    v.rxv = rxv; v.pc = pc; v.fl = fl; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.txr = txr;
    v.e_rxr = e_rxr; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_txv = e_txv;
    v.e_txpc = e_txpc; v.e_inst = e_inst;
    vq.push_back(v);
  endtask

  task automatic drive(input logic rxv, input logic [31:0] pc, input logic fl, input logic rqr,
                       input logic rsv, input logic [31:0] rsd, input logic txr);
    ifu_rx_valid = rxv; ifu_rx_pc = pc; ifu_flush = fl; ifu_mem_req_ready = rqr;
    ifu_mem_rsp_valid = rsv; ifu_mem_rsp_data = rsd; ifu_tx_ready = txr;
  endtask

  // Inputs change 1 time unit after a rising edge. Outputs are sampled 2
  // units later, which keeps every sample well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tx_first;
    int rx_first;
    logic rsp_pend;
    logic [31:0] tx_inst_seen;

    // ---------------- stimulus table ----------------
    // rxv pc            fl rqr rsv rsd            txr | rxr rqv addr          txv txpc          inst
    add(1, 32'h8000_0000, 0, 0, 0, 32'h0,         0,   1, 0, 32'h0,         0, 32'h0,         NOP);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0000, 0, 32'h8000_0000, NOP);
    add(0, 32'h0,         0, 0, 1, 32'h0000_0093, 0,   0, 0, 32'h8000_0000, 0, 32'h8000_0000, NOP);
    // tx backpressure for 5 cycles: outputs hold, rx and stray rsp ignored
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    add(1, 32'h0000_1234, 0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    add(0, 32'h0,         0, 0, 1, 32'hFFFF_FFFF, 0,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    add(0, 32'h0,         0, 0, 0, 32'h0,         1,   0, 0, 32'h8000_0000, 1, 32'h8000_0000, 32'h93);
    // req backpressure 3 cycles, then a 2-cycle memory
    add(1, 32'h8000_0004, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0000, 0, 32'h8000_0000, 32'h93);
    add(1, 32'h0000_9999, 0, 0, 0, 32'h0,         0,   0, 1, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(1, 32'h0000_9999, 0, 0, 0, 32'h0,         0,   0, 1, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(1, 32'h0000_9999, 0, 0, 0, 32'h0,         0,   0, 1, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(0, 32'h0,         0, 0, 1, 32'h0010_0113, 0,   0, 0, 32'h8000_0004, 0, 32'h8000_0004, 32'h93);
    add(0, 32'h0,         0, 0, 0, 32'h0,         1,   0, 0, 32'h8000_0004, 1, 32'h8000_0004, 32'h0010_0113);
    // flush in S_RSP, response arrives two cycles later and is drained
    add(1, 32'h8000_0008, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0004, 0, 32'h8000_0004, 32'h0010_0113);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    add(0, 32'h0,         1, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    add(0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0,   0, 0, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    // next fetch after the flush completes normally
    add(1, 32'h8000_0100, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0008, 0, 32'h8000_0008, 32'h0010_0113);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0100, 0, 32'h8000_0100, 32'h0010_0113);
    add(0, 32'h0,         0, 0, 1, 32'h0000_0517, 0,   0, 0, 32'h8000_0100, 0, 32'h8000_0100, 32'h0010_0113);
    add(0, 32'h0,         0, 0, 0, 32'h0,         1,   0, 0, 32'h8000_0100, 1, 32'h8000_0100, 32'h517);
    // flush in S_REQ (req_ready high too), then a stray rsp in IDLE
    add(1, 32'h8000_0200, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0100, 0, 32'h8000_0100, 32'h517);
    add(0, 32'h0,         1, 1, 0, 32'h0,         0,   0, 0, 32'h8000_0200, 0, 32'h8000_0200, 32'h517);
    add(0, 32'h0,         0, 0, 1, 32'hBAD0_BAD0, 0,   1, 0, 32'h8000_0200, 0, 32'h8000_0200, 32'h517);
    // flush and rsp in the same S_RSP cycle: data discarded, straight to IDLE
    add(1, 32'h8000_0300, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0200, 0, 32'h8000_0200, 32'h517);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0300, 0, 32'h8000_0300, 32'h517);
    add(0, 32'h0,         1, 0, 1, 32'hCAFE_0000, 0,   0, 0, 32'h8000_0300, 0, 32'h8000_0300, 32'h517);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0300, 0, 32'h8000_0300, 32'h517);
    // flush in S_TX with tx_ready=1, then flush in IDLE blocks rx
    add(1, 32'h8000_0400, 0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0300, 0, 32'h8000_0300, 32'h517);
    add(0, 32'h0,         0, 1, 0, 32'h0,         0,   0, 1, 32'h8000_0400, 0, 32'h8000_0400, 32'h517);
    add(0, 32'h0,         0, 0, 1, 32'h00A0_0093, 0,   0, 0, 32'h8000_0400, 0, 32'h8000_0400, 32'h517);
    add(0, 32'h0,         1, 0, 0, 32'h0,         1,   0, 0, 32'h8000_0400, 0, 32'h8000_0400, 32'h00A0_0093);
    add(1, 32'h8000_0500, 1, 0, 0, 32'h0,         0,   0, 0, 32'h8000_0400, 0, 32'h8000_0400, 32'h00A0_0093);
    add(0, 32'h0,         0, 0, 0, 32'h0,         0,   1, 0, 32'h8000_0400, 0, 32'h8000_0400, 32'h00A0_0093);

    // ---------------- reset ----------------
    rstn = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #2;
    check("reset rx_ready",  {31'h0, ifu_rx_ready},      32'h1);
    check("reset req_valid", {31'h0, ifu_mem_req_valid}, 32'h0);
    check("reset tx_valid",  {31'h0, ifu_tx_valid},      32'h0);
    check("reset tx_pc",     ifu_tx_pc,                  32'h0);
    check("reset tx_inst",   ifu_tx_inst,                NOP);
    check("reset misalign",  {31'h0, ifu_tx_misalign},   32'h0);
    tick();

    // ---------------- table ----------------
    foreach (vq[i]) begin
      drive(vq[i].rxv, vq[i].pc, vq[i].fl, vq[i].rqr, vq[i].rsv, vq[i].rsd, vq[i].txr);
      #2;
      check($sformatf("row%0d rx_ready", i),  {31'h0, ifu_rx_ready},      {31'h0, vq[i].e_rxr});
      check($sformatf("row%0d req_valid", i), {31'h0, ifu_mem_req_valid}, {31'h0, vq[i].e_rqv});
      check($sformatf("row%0d req_addr", i),  ifu_mem_req_addr,           vq[i].e_addr);
      check($sformatf("row%0d tx_valid", i),  {31'h0, ifu_tx_valid},      {31'h0, vq[i].e_txv});
      check($sformatf("row%0d tx_pc", i),     ifu_tx_pc,                  vq[i].e_txpc);
      check($sformatf("row%0d tx_inst", i),   ifu_tx_inst,                vq[i].e_inst);
      check($sformatf("row%0d misalign", i),  {31'h0, ifu_tx_misalign},   32'h0);
      tick();
    end

    // ---------------- latency: one-cycle memory, tx_ready=1 ----------------
    // PC accepted in cycle 0 -> tx_valid first in cycle 3, rx_ready back in 4.
    tx_first = -1;
    rx_first = -1;
    rsp_pend = 1'b0;
    tx_inst_seen = 32'h0;
    for (int c = 0; c < 20; c++) begin
      drive(c == 0, 32'h8000_0600, 0, 1, rsp_pend, 32'h0000_0297, 1);
      #2;
      if (ifu_tx_valid && tx_first < 0) begin
        tx_first = c;
        tx_inst_seen = ifu_tx_inst;
      end
      rsp_pend = ifu_mem_req_valid && ifu_mem_req_ready;
      if (c > 0 && ifu_rx_ready) begin
        rx_first = c;
        tick();
        break;
      end
      tick();
    end
    check("latency tx_valid cycle", tx_first,     32'd3);
    check("latency rx_ready cycle", rx_first,     32'd4);
    check("latency tx_inst",        tx_inst_seen, 32'h0000_0297);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0);

    // ---------------- misaligned PC ----------------
    drive(1, 32'h8000_0002, 0, 0, 0, 32'h0, 0);
    tick();
    drive(0, 32'h0, 0, 1, 0, 32'h0, 0);
    #2;
`ifdef IFU_MISALIGN_TRAP_EN
    check("mis req_valid", {31'h0, ifu_mem_req_valid}, 32'h0);
    check("mis tx_valid",  {31'h0, ifu_tx_valid},      32'h1);
    check("mis flag",      {31'h0, ifu_tx_misalign},   32'h1);
    check("mis tx_inst",   ifu_tx_inst,                NOP);
    check("mis tx_pc",     ifu_tx_pc,                  32'h8000_0002);
    ifu_tx_ready = 1'b1;
    tick();
`else
    check("mis req_valid", {31'h0, ifu_mem_req_valid}, 32'h1);
    check("mis req_addr",  ifu_mem_req_addr,           32'h8000_0002);
    check("mis flag",      {31'h0, ifu_tx_misalign},   32'h0);
    tick();
    drive(0, 32'h0, 0, 0, 1, 32'h0000_0033, 0);
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 1);
    #2;
    check("mis tx_valid",  {31'h0, ifu_tx_valid},      32'h1);
    check("mis tx_inst",   ifu_tx_inst,                32'h0000_0033);
    check("mis flag tx",   {31'h0, ifu_tx_misalign},   32'h0);
    tick();
`endif
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
    #2;
    check("mis back idle", {31'h0, ifu_rx_ready}, 32'h1);
    tick();

    // ---------------- reset in the middle of a fetch ----------------
    drive(1, 32'h8000_0700, 0, 0, 0, 32'h0, 0);
    tick();
    drive(0, 32'h0, 0, 1, 0, 32'h0, 0);
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
    #2 rstn = 1'b0;
    #1;
    check("midrst tx_pc",   ifu_tx_pc,   32'h0);
    check("midrst tx_inst", ifu_tx_inst, NOP);
    tick();
    rstn = 1'b1;
    #2;
    check("midrst rx_ready",  {31'h0, ifu_rx_ready},      32'h1);
    check("midrst tx_valid",  {31'h0, ifu_tx_valid},      32'h0);
    check("midrst req_valid", {31'h0, ifu_mem_req_valid}, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the consumer end of the PC register's valid/ready PC stream. Accepts one PC at a time, issues a single-outstanding read to instruction memory, and presents the fetched {pc, inst} pair to the decode stage over a valid/ready handshake. A flush input from the branch path discards any fetch in flight.

## Interface
Parameters:
- `RESET_INST`, default 32'h0000_0013, value of `ifu_tx_inst` at reset and on a misaligned-PC trap (NOP).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `ifu_rx_valid`  in  1  PC valid from the PC register.
- `ifu_rx_ready`  out  1  fetch unit can accept a PC.
- `ifu_rx_pc`  in  32  PC to fetch.
- `ifu_flush`  in  1  branch/jump redirect; kill the in-flight fetch.
- `ifu_mem_req_valid`  out  1  instruction memory read request.
- `ifu_mem_req_ready`  in  1  memory accepts the request.
- `ifu_mem_req_addr`  out  32  read byte address.
- `ifu_mem_rsp_valid`  in  1  read data valid (one pulse per accepted request).
- `ifu_mem_rsp_data`  in  32  read data.
- `ifu_tx_valid`  out  1  fetched instruction valid to the decode stage.
- `ifu_tx_ready`  in  1  decode stage accepts.
- `ifu_tx_pc`  out  32  PC of the presented instruction.
- `ifu_tx_inst`  out  32  instruction word.
- `ifu_tx_misalign`  out  1  presented PC is misaligned (see Configuration).

## Operation
- States: S_IDLE, S_REQ, S_RSP, S_DRAIN, S_TX. Registers: `pc_q`, `inst_q`, `mis_q`.
- S_IDLE: `ifu_rx_ready = !ifu_flush`. When rx handshake occurs: `pc_q <= ifu_rx_pc`, then go to S_REQ.
- S_REQ: `ifu_mem_req_valid = !ifu_flush`, `ifu_mem_req_addr = pc_q`. On flush, go to S_IDLE (no request issued). On req handshake, go to S_RSP.
- S_RSP: on `ifu_mem_rsp_valid`, set `inst_q <= ifu_mem_rsp_data` and go to S_TX. If `ifu_flush` is high without rsp, go to S_DRAIN. If flush and rsp arrive in the same cycle, discard the data and go to S_IDLE.
- S_DRAIN: wait for `ifu_mem_rsp_valid`, discard the data, then go to S_IDLE. Flush here has no further effect.
- S_TX: `ifu_tx_valid = !ifu_flush`; `ifu_tx_pc = pc_q`, `ifu_tx_inst = inst_q`. On tx handshake or flush, go to S_IDLE. Flush has priority, so no handshake occurs in a flush cycle.
- At most one memory request is outstanding. `ifu_rx_ready` is low in every state except S_IDLE.
- `rsp_valid` outside S_RSP/S_DRAIN is ignored.

## Timing
- Reset (async): state S_IDLE; `pc_q`=0, `inst_q`=`RESET_INST`, `mis_q`=0.
  - Outputs: `ifu_rx_ready`=1 (after rstn deasserts), `ifu_mem_req_valid`=0, `ifu_tx_valid`=0, `ifu_tx_pc`=0, `ifu_tx_inst`=`RESET_INST`, `ifu_tx_misalign`=0.
- Reset mid-fetch drops all state. The memory is reset by the same `rstn`, so no stale response follows.
- PC accepted in cycle N:
  - `req_valid` goes high in N+1.
  - With `req_ready`=1 and a one-cycle memory (rsp in N+2), `ifu_tx_valid` goes high in N+3.
  - With `tx_ready`=1, `ifu_rx_ready` goes high in N+4.
- Minimum 4 cycles per instruction. No combinational path from `ifu_rx_*` to `ifu_mem_*` or `ifu_tx_*`.
- `ifu_flush` acts combinationally on ready/valid outputs in the same cycle and on state at the next edge.
- `ifu_tx_*` stay stable while `ifu_tx_valid`=1 and `ifu_tx_ready`=0.

## Configuration
- `IFU_MISALIGN_TRAP_EN` defined:
  - At rx handshake, `mis_q <= |ifu_rx_pc[1:0]`.
  - If set, skip S_REQ/S_RSP and go directly to S_TX with `inst_q <= RESET_INST` and `ifu_tx_misalign`=1. No memory request is issued.
- Not defined:
  - `ifu_tx_misalign` is tied to 0.
  - Misaligned PCs are fetched normally, with `ifu_mem_req_addr = pc_q` unmodified.

## Test plan
- Reset: hold rstn=0, then release → `ifu_rx_ready`=1, `ifu_tx_valid`=0, `ifu_tx_inst`=0x00000013, `ifu_mem_req_valid`=0.
- Basic fetch: send pc=0x8000_0000; memory answers 0x0000_0093 one cycle after request → `ifu_tx_valid` with pc=0x8000_0000, inst=0x0000_0093 three cycles after rx; with tx_ready=0 for 5 cycles, outputs hold.
- Backpressure: `req_ready`=0 for 3 cycles → `req_valid`/addr held at 0x8000_0004, `ifu_rx_ready`=0 throughout.
- Flush in S_RSP: flush one cycle after req handshake, response 0xDEADBEEF two cycles later → no `ifu_tx_valid`, `ifu_rx_ready`=1 the cycle after the response; the next pc=0x8000_0100 fetches correctly.
- Flush in S_TX with `tx_ready`=1 in the same cycle → no handshake counted, state S_IDLE next cycle.
- Misalign (macro defined): pc=0x8000_0002 → no `req_valid`, `ifu_tx_valid` next cycle with misalign=1, inst=0x00000013. Without the macro: a request is issued to 0x8000_0002 and misalign stays 0.
